// File: rtl/lbus_pkg.sv
// rtl/lbus_pkg.sv - shared local-bus constants, state type and helpers
package lbus_pkg;

    localparam int          LBUS_ADDR_W      = 32;
    localparam int          LBUS_DATA_W      = 32;
    localparam int          LBUS_STRB_W      = LBUS_DATA_W / 8;
    localparam int          LBUS_TIMEOUT_CYC = 16;
    localparam logic [31:0] LBUS_ERR_RDATA   = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RESP
    } lbus_state_e;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/lbus_timeout_ctr.sv
// rtl/lbus_timeout_ctr.sv - wait-cycle counter flagging the last allowed cycle
module lbus_timeout_ctr #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q == LAST);

    // Holds at LAST so a stalled enable can never wrap back to zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lbus_master.sv
// rtl/lbus_master.sv - single-outstanding CPU-to-local-bus initiator
module lbus_master
    import lbus_pkg::*;
#(
    parameter int                ADDR_W      = LBUS_ADDR_W,
    parameter int                DATA_W      = LBUS_DATA_W,
    parameter int                STRB_W      = DATA_W / 8,
    parameter int                TIMEOUT_CYC = LBUS_TIMEOUT_CYC,
    parameter logic [DATA_W-1:0] ERR_RDATA   = DATA_W'(LBUS_ERR_RDATA)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wen,
    input  logic              wready,
    output logic [ADDR_W-1:0] raddr,
    output logic              ren,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid
);

    lbus_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              ctr_clr;
    logic              ctr_en;
    logic              ctr_expired;

    lbus_timeout_ctr #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk_i    (clk),
        .rst_ni   (rst),
        .clr_i    (ctr_clr),
        .en_i     (ctr_en),
        .expired_o(ctr_expired)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        req_ready = 1'b0;
        wen       = 1'b0;
        ren       = 1'b0;
        ctr_clr   = 1'b1;
        ctr_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (is_misaligned(req_addr[1:0])) begin
                        err_d   = 1'b1;
                        rdata_d = req_write ? '0 : ERR_RDATA;
                        state_d = S_RESP;
                    end else if (req_write) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD_ISSUE;
                    end
                end
            end

            S_WR: begin
                wen     = 1'b1;
                ctr_clr = 1'b0;
                ctr_en  = 1'b1;
                if (wready) begin
                    state_d = S_RESP;
                end else if (ctr_expired) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end

            // rvalid here may be left over from a previous access, so it is ignored
            S_RD_ISSUE: begin
                ren     = 1'b1;
                state_d = S_RD_WAIT;
            end

            // rvalid is tested before expiry so a last-cycle response still succeeds
            S_RD_WAIT: begin
                ren     = 1'b1;
                ctr_clr = 1'b0;
                ctr_en  = 1'b1;
                if (rvalid) begin
                    rdata_d = rdata;
                    state_d = S_RESP;
                end else if (ctr_expired) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_RDATA;
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign waddr = wen ? addr_q  : '0;
    assign wdata = wen ? wdata_q : '0;
    assign wstrb = wen ? wstrb_q : '0;
    assign raddr = ren ? addr_q  : '0;

endmodule

// File: tb/tb_lbus_master.sv
// tb/tb_lbus_master.sv - self-checking bench for lbus_master
module tb_lbus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wen;
    logic        wready;
    logic [31:0] raddr;
    logic        ren;
    logic [31:0] rdata = '0;
    logic        rvalid = 1'b0;

    int checks = 0;
    int errors = 0;
    int viol = 0;

    logic [31:0] mem[16] = '{default: 32'h0};
    logic [31:0] model_mem[16] = '{default: 32'h0};
    int rsp_lat = 0;
    bit rsp_silent = 1'b0;
    int wcnt = 0;
    int rcnt = 0;

    always #5 clk = ~clk;

    lbus_master dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .waddr     (waddr),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wen       (wen),
        .wready    (wready),
        .raddr     (raddr),
        .ren       (ren),
        .rdata     (rdata),
        .rvalid    (rvalid)
    );

    // Responder: write accepted after rsp_lat wen cycles, read data registered rsp_lat cycles after ren
    assign wready = wen && !rsp_silent && (wcnt >= rsp_lat);

    always @(posedge clk) begin
        wcnt <= wen ? wcnt + 1 : 0;
        rcnt <= ren ? rcnt + 1 : 0;
        if (ren && !rvalid && !rsp_silent && rcnt >= rsp_lat) begin
            rvalid <= 1'b1;
            rdata  <= mem[raddr[5:2]];
        end else begin
            rvalid <= 1'b0;
        end
        if (wen && wready) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[waddr[5:2]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (wen && ren) viol++;
            if (!wen && (waddr != 0 || wdata != 0 || wstrb != 0)) viol++;
            if (!ren && raddr != 0) viol++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Behavioural reference: latency and outcome from the access rules, TIMEOUT_CYC = 16
    task automatic ref_model(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int lat,
                             output logic [31:0] e_rd, output logic e_err,
                             output int e_lat, output int e_wen, output int e_ren);
        bit answered;
        answered = (lat < 16);
        e_wen = 0;
        e_ren = 0;
        if (a[1:0] != 2'b00) begin
            e_err = 1'b1;
            e_rd  = w ? 32'h0 : 32'hDEAD_BEEF;
            e_lat = 1;
        end else if (w) begin
            e_err = !answered;
            e_rd  = 32'h0;
            e_wen = answered ? lat + 1 : 16;
            e_lat = e_wen + 1;
            if (answered) model_mem[a[5:2]] = merge(model_mem[a[5:2]], d, s);
        end else begin
            e_err = !answered;
            e_rd  = answered ? model_mem[a[5:2]] : 32'hDEAD_BEEF;
            e_ren = answered ? lat + 2 : 17;
            e_lat = e_ren + 1;
        end
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int lat, input int hold,
                          output logic [31:0] rd, output logic er, output int nlat,
                          output int nwen, output int nren, output bit stable_ok);
        int guard;
        rd = '0; er = 1'b0; nlat = 0; nwen = 0; nren = 0; stable_ok = 1'b1;
        @(negedge clk);
        rsp_lat    = lat;
        rsp_silent = (lat >= 16);
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        req_wstrb  = s;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("req_ready_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        guard = 0;
        while (guard < 100) begin
            @(negedge clk);
            nlat++;
            if (wen) nwen++;
            if (ren) nren++;
            if (resp_valid) break;
            guard++;
        end
        if (guard >= 100) check("resp_valid_timeout", 32'h0, 32'h1);
        rd = resp_rdata;
        er = resp_err;
        for (int h = 0; h < hold; h++) begin
            if (!resp_valid || resp_rdata !== rd || resp_err !== er || req_ready) stable_ok = 1'b0;
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          lat;
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat;
        int          e_wen;
        int          e_ren;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [31:0] rd, e_rd;
        logic        er, e_err;
        int          nlat, nwen, nren, e_lat, e_wen, e_ren, hs;
        bit          st;

        tbl[0]  = '{1'b1, 32'h10, 32'h0000_00A5, 4'hF,  0, 32'h0,         1'b0,  2,  1,  0};
        tbl[1]  = '{1'b1, 32'h24, 32'h0000_0001, 4'hF,  0, 32'h0,         1'b0,  2,  1,  0};
        tbl[2]  = '{1'b0, 32'h24, 32'h0,         4'h0,  0, 32'h1,         1'b0,  3,  0,  2};
        tbl[3]  = '{1'b0, 32'h22, 32'h0,         4'h0,  0, 32'hDEAD_BEEF, 1'b1,  1,  0,  0};
        tbl[4]  = '{1'b1, 32'h13, 32'h99,        4'hF,  0, 32'h0,         1'b1,  1,  0,  0};
        tbl[5]  = '{1'b0, 32'h30, 32'h0,         4'h0, 16, 32'hDEAD_BEEF, 1'b1, 18,  0, 17};
        tbl[6]  = '{1'b1, 32'h30, 32'h55,        4'hF, 16, 32'h0,         1'b1, 17, 16,  0};
        tbl[7]  = '{1'b0, 32'h30, 32'h0,         4'h0,  0, 32'h0,         1'b0,  3,  0,  2};
        tbl[8]  = '{1'b1, 32'h14, 32'hAABB_CCDD, 4'h5,  3, 32'h0,         1'b0,  5,  4,  0};
        tbl[9]  = '{1'b0, 32'h14, 32'h0,         4'h0,  2, 32'h00BB_00DD, 1'b0,  5,  0,  4};
        tbl[10] = '{1'b1, 32'h18, 32'h1234_5678, 4'hF, 15, 32'h0,         1'b0, 17, 16,  0};
        tbl[11] = '{1'b0, 32'h18, 32'h0,         4'h0, 15, 32'h1234_5678, 1'b0, 18,  0, 17};
        tbl[12] = '{1'b0, 32'h10, 32'h0,         4'h0,  1, 32'h0000_00A5, 1'b0,  4,  0,  3};

        repeat (3) @(negedge clk);
        check("rst_wen", {31'h0, wen}, 32'h0);
        check("rst_ren", {31'h0, ren}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_bus_addr", waddr | raddr, 32'h0);

        for (int i = 0; i < 13; i++) begin
            ref_model(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].lat, e_rd, e_err, e_lat, e_wen, e_ren);
            do_req(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].lat, 0, rd, er, nlat, nwen, nren, st);
            check($sformatf("tbl%0d_rdata", i), rd, tbl[i].e_rd);
            check($sformatf("tbl%0d_err", i), {31'h0, er}, {31'h0, tbl[i].e_err});
            check($sformatf("tbl%0d_latency", i), nlat, tbl[i].e_lat);
            check($sformatf("tbl%0d_wen_cycles", i), nwen, tbl[i].e_wen);
            check($sformatf("tbl%0d_ren_cycles", i), nren, tbl[i].e_ren);
            check($sformatf("tbl%0d_rvalid_after", i), {31'h0, rvalid}, 32'h0);
        end

        // Response held off for five cycles
        do_req(1'b0, 32'h24, 32'h0, 4'h0, 0, 5, rd, er, nlat, nwen, nren, st);
        check("hold_rdata", rd, 32'h1);
        check("hold_stable", {31'h0, st}, 32'h1);

        // Back-to-back writes with resp_ready tied high
        @(negedge clk);
        rsp_lat = 0; rsp_silent = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h3C; req_wdata = 32'h77; req_wstrb = 4'hF;
        resp_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 12; c++) begin
            if (req_ready) hs++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        resp_ready = 1'b0;
        model_mem[15] = 32'h77;
        check("throughput_handshakes", hs, 4);

        // Reset while waiting on a silent read responder
        @(negedge clk);
        rsp_silent = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_ren_before", {31'h0, ren}, 32'h1);
        #2 rst = 1'b0;
        #1;
        check("midrst_ren", {31'h0, ren}, 32'h0);
        check("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, rd, er, nlat, nwen, nren, st);
        check("postrst_rdata", rd, 32'hA5);
        check("postrst_err", {31'h0, er}, 32'h0);
        check("postrst_latency", nlat, 3);

        for (int i = 0; i < 40; i++) begin
            logic        w;
            logic [31:0] a, d;
            logic [3:0]  s;
            int          lat, hold;
            w    = 1'($urandom_range(0, 1));
            a    = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
            d    = $urandom;
            s    = 4'($urandom_range(0, 15));
            lat  = $urandom_range(0, 17);
            hold = $urandom_range(0, 2);
            ref_model(w, a, d, s, lat, e_rd, e_err, e_lat, e_wen, e_ren);
            do_req(w, a, d, s, lat, hold, rd, er, nlat, nwen, nren, st);
            check($sformatf("rnd%0d_rdata", i), rd, e_rd);
            check($sformatf("rnd%0d_err", i), {31'h0, er}, {31'h0, e_err});
            check($sformatf("rnd%0d_latency", i), nlat, e_lat);
            check($sformatf("rnd%0d_wen_cycles", i), nwen, e_wen);
            check($sformatf("rnd%0d_ren_cycles", i), nren, e_ren);
            check($sformatf("rnd%0d_stable", i), {31'h0, st}, 32'h1);
        end

        check("bus_exclusive_and_zero", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lbus_master.md
# lbus_master

Single-outstanding initiator for the peripheral local bus (waddr/wdata/wen/wstrb/wready, raddr/ren/rdata/rvalid). It accepts CPU load/store requests on a valid/ready channel and drives one local-bus transaction at a time toward peripheral register blocks such as the PWM CSR file. It returns read data or a write acknowledge, with error on misalignment or responder timeout.

## Interface
- ADDR_W, 32, local-bus and request address width
- DATA_W, 32, data width
- STRB_W, DATA_W/8, byte-strobe width
- TIMEOUT_CYC, 16, wait cycles for wready/rvalid before error (≥2)
- ERR_RDATA, 32'hDEAD_BEEF, resp_rdata value on error read
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  CPU request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data
- req_wstrb  in  STRB_W  store byte enables
- resp_valid  out  1  response valid, held until resp_ready
- resp_ready  in  1  CPU accepts response
- resp_rdata  out  DATA_W  load data (0 for stores)
- resp_err  out  1  misaligned or timed-out access
- waddr / wdata / wstrb  out  ADDR_W / DATA_W / STRB_W  local-bus write address/data/strobes
- wen  out  1  write enable
- wready  in  1  responder write accept
- raddr  out  ADDR_W  local-bus read address
- ren  out  1  read enable
- rdata  in  DATA_W  responder read data
- rvalid  in  1  responder read valid

## Operation
- States: IDLE, WR, RD_ISSUE, RD_WAIT, RESP.
- IDLE: req_ready=1. On handshake, register addr/wdata/wstrb/write. If req_addr[1:0]≠0 → RESP with err=1, no bus activity; else write → WR, read → RD_ISSUE.
- WR: wen=1, waddr/wdata/wstrb from registered request. wready=1 → RESP (err=0, rdata=0). Timeout → RESP, err=1, wen drops.
- RD_ISSUE: ren=1, raddr driven; rvalid ignored this cycle (may be stale). → RD_WAIT.
- RD_WAIT: ren stays 1. rvalid=1 → capture rdata into resp_rdata, → RESP; ren still high in the capture cycle so responder clears its rvalid. Timeout → RESP, err=1, resp_rdata=ERR_RDATA.
- RESP: resp_valid=1, outputs stable; resp_ready → IDLE. New request not accepted in the same cycle.
- Timeout counter: clears on entry to WR/RD_WAIT, increments per waiting cycle, expires at TIMEOUT_CYC−1. Width $clog2(TIMEOUT_CYC+1).
- wen and ren never both high. Bus address/data outputs are 0 when their enable is low.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE; req_ready=1 after deassert; resp_valid, resp_err, wen, ren=0; all bus/data outputs 0; counter 0.
- Reset mid-transaction: bus enables drop immediately, pending response discarded.
- Write: handshake at T, wen at T+1, wready=1 → resp_valid at T+2.
- Read with a one-cycle registered responder: handshake T, ren T+1..T+2, rvalid seen T+2, resp_valid T+3.
- Misaligned: resp_valid at T+1.
- Throughput: at most one request per 3 cycles (write, resp_ready tied 1).
- rvalid and timeout expiry in the same cycle: rvalid wins, err=0.

## Structure
- Package lbus_pkg: state enum lbus_state_e, ERR_RDATA default, local-bus width constants shared with CSR blocks.
- Optional sub-module lbus_timeout_ctr (clear/enable/expired). Everything else in lbus_master.

## Test plan
- Write 0x10, data 0x0000_00A5, strb 0xF, responder wready=1 → wen 1 cycle with waddr=0x10, resp_valid at T+2, err=0.
- Read 0x24, responder returns 0x1 one cycle after ren → ren exactly 2 cycles, resp_rdata=0x1 at T+3, responder rvalid low afterward.
- Read address 0x22 → no ren/wen, resp_valid at T+1, err=1.
- Read to silent responder, TIMEOUT_CYC=16 → ren drops after timeout, resp_rdata=0xDEADBEEF, err=1. Repeat with wready=0 for writes.
- resp_ready held 0 for 5 cycles → resp fields stable, req_ready=0, then return to IDLE.
- rst asserted during RD_WAIT → ren=0 immediately, resp_valid=0. Next read after release completes normally.
